// File: rtl/de4_qsys_sysid_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// de4_qsys_sysid_arbiter_pkg
//
// Shared defaults for the sysid read arbiter and a helper that sizes the
// round-robin pointer / winner index.
//
// Contents:
//   DEF_N_MASTERS  default number of requesting masters
//   DEF_DATA_W     default readdata width
//   DEF_ADDR_W     default word address width of the shared slave
//   idx_width()    bits needed to hold a master index, clog2(n)
// -----------------------------------------------------------------------------
package de4_qsys_sysid_arbiter_pkg;

    localparam int unsigned DEF_N_MASTERS = 4;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_ADDR_W    = 1;

    // Never return 0: a 1-bit index is still needed for the degenerate case.
    function automatic int unsigned idx_width(input int unsigned n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//
// Purely combinational round-robin selector. The search starts at ptr+1
// (mod N) and walks the request vector once; the first requester found wins.
//
// Ports:
//   req    in   N bits      request vector
//   ptr    in   IDX_W bits  index of the most recent winner
//   grant  out  N bits      one-hot grant, zero when no request
//   idx    out  IDX_W bits  binary index of the winner (0 when none)
//   any    out  1 bit       a winner exists
// -----------------------------------------------------------------------------
module rr_pick
    import de4_qsys_sysid_arbiter_pkg::*;
#(
    parameter int unsigned N     = DEF_N_MASTERS,
    parameter int unsigned IDX_W = idx_width(DEF_N_MASTERS)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        cand  = '0;
        // k = N revisits ptr itself last, so a lone requester at ptr still wins.
        for (int k = 1; k <= int'(N); k++) begin
            cand = IDX_W'((int'(ptr) + k) % int'(N));
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/de4_qsys_sysid_arbiter.sv
// -----------------------------------------------------------------------------
// de4_qsys_sysid_arbiter
//
// Round-robin arbiter letting N_MASTERS Avalon-MM read masters share one
// zero-wait-state combinational register slave (e.g. a system ID block).
// One read is accepted per cycle; its data returns exactly one cycle later
// on the shared m_readdata bus, qualified by a one-hot m_readdatavalid.
//
// Ports:
//   clock            in   sole clock, rising edge
//   reset            in   synchronous active-high reset
//   m_read           in   [N_MASTERS]          per-master read request
//   m_address        in   [N_MASTERS*ADDR_W]   per-master word address (slice i)
//   m_waitrequest    out  [N_MASTERS]          per-master stall
//   m_readdatavalid  out  [N_MASTERS]          per-master response strobe
//   m_readdata       out  [DATA_W]             shared response data
//   s_read           out  read strobe to the slave
//   s_address        out  [ADDR_W]             address to the slave
//   s_readdata       in   [DATA_W]             slave read data (same cycle)
// -----------------------------------------------------------------------------
module de4_qsys_sysid_arbiter
    import de4_qsys_sysid_arbiter_pkg::*;
#(
    parameter int unsigned N_MASTERS = DEF_N_MASTERS,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ADDR_W    = DEF_ADDR_W
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [N_MASTERS-1:0]          m_read,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_address,
    output logic [N_MASTERS-1:0]          m_waitrequest,
    output logic [N_MASTERS-1:0]          m_readdatavalid,
    output logic [DATA_W-1:0]             m_readdata,
    output logic                          s_read,
    output logic [ADDR_W-1:0]             s_address,
    input  logic [DATA_W-1:0]             s_readdata
);

    localparam int unsigned IDX_W = idx_width(N_MASTERS);
    localparam logic [IDX_W-1:0] PTR_RESET = IDX_W'(N_MASTERS - 1);

    logic [IDX_W-1:0]     ptr_q, ptr_d;
    logic [N_MASTERS-1:0] valid_q, valid_d;
    logic [DATA_W-1:0]    rdata_q, rdata_d;

    logic [N_MASTERS-1:0] req;
    logic [N_MASTERS-1:0] grant;
    logic [IDX_W-1:0]     win_idx;
    logic                 win_any;

    // No grant can be issued while reset is held.
    assign req = reset ? '0 : m_read;

    rr_pick #(
        .N     (N_MASTERS),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (grant),
        .idx   (win_idx),
        .any   (win_any)
    );

    // Slave-side request and master-side stall.
    always_comb begin
        s_read        = win_any;
        s_address     = '0;
        m_waitrequest = m_read & ~grant;
        // One-hot AND-OR mux; stays zero when nobody is granted.
        for (int i = 0; i < int'(N_MASTERS); i++) begin
            if (grant[i]) begin
                s_address = s_address | m_address[i*ADDR_W +: ADDR_W];
            end
        end
    end

    // Next state: ptr tracks the last winner, data is captured only on accept
    // so m_readdata holds between responses.
    always_comb begin
        ptr_d   = ptr_q;
        rdata_d = rdata_q;
        valid_d = grant;
        if (win_any) begin
            ptr_d   = win_idx;
            rdata_d = s_readdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q   <= PTR_RESET;
            valid_q <= '0;
            rdata_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
        end
    end

    // Response outputs are forced quiet during reset, which also kills a
    // response that was already registered when reset arrived.
    always_comb begin
        m_readdatavalid = reset ? '0 : valid_q;
        m_readdata      = reset ? '0 : rdata_q;
    end

    grant_onehot_a : assert property (@(posedge clock) $onehot0(grant));
    valid_onehot_a : assert property (@(posedge clock) $onehot0(m_readdatavalid));
    sread_match_a  : assert property (@(posedge clock) s_read == (grant != '0));

endmodule

// File: tb/tb_de4_qsys_sysid_arbiter.sv
module tb_de4_qsys_sysid_arbiter;

    localparam int N  = 4;
    localparam int AW = 1;
    localparam int DW = 32;

    logic              clock = 1'b0;
    logic              reset;
    logic [N-1:0]      m_read;
    logic [N*AW-1:0]   m_address;
    logic [N-1:0]      m_waitrequest;
    logic [N-1:0]      m_readdatavalid;
    logic [DW-1:0]     m_readdata;
    logic              s_read;
    logic [AW-1:0]     s_address;
    logic [DW-1:0]     s_readdata;

    logic [DW-1:0]     mem [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference state: last winner, pending response, held data.
    int          ptr_m  = N - 1;
    bit          pend_v = 1'b0;
    int          pend_m = 0;
    logic [31:0] rd_m   = '0;

    de4_qsys_sysid_arbiter #(
        .N_MASTERS (N),
        .DATA_W    (DW),
        .ADDR_W    (AW)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .m_read          (m_read),
        .m_address       (m_address),
        .m_waitrequest   (m_waitrequest),
        .m_readdatavalid (m_readdatavalid),
        .m_readdata      (m_readdata),
        .s_read          (s_read),
        .s_address       (s_address),
        .s_readdata      (s_readdata)
    );

    always #5 clock = ~clock;

    // Zero-wait combinational slave.
    always_comb s_readdata = mem[s_address];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int p, input logic [N-1:0] rd);
        for (int k = 1; k <= N; k++) begin
            if (rd[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    // One clock cycle: apply inputs, check mid-cycle against the model,
    // then advance the model across the rising edge.
    task automatic step(input logic rst, input logic [N-1:0] rd, input logic [N*AW-1:0] ad,
                        output logic [N-1:0] wr_seen);
        int          w;
        logic [N-1:0] g;
        logic [AW-1:0] a;
        logic [N-1:0] ev;
        reset = rst; m_read = rd; m_address = ad;
        #4;
        w = rst ? -1 : pick(ptr_m, rd);
        g = '0;
        a = '0;
        if (w >= 0) begin
            g[w] = 1'b1;
            a = ad[w*AW +: AW];
        end
        ev = '0;
        if (!rst && pend_v) ev[pend_m] = 1'b1;
        check_eq("waitrequest", m_waitrequest, rd & ~g);
        check_eq("s_read", s_read, (w >= 0));
        check_eq("s_address", s_address, a);
        check_eq("readdatavalid", m_readdatavalid, ev);
        check_eq("readdata", m_readdata, rst ? 32'h0 : rd_m);
        wr_seen = m_waitrequest;
        @(posedge clock);
        #1;
        if (rst) begin
            ptr_m = N - 1; pend_v = 1'b0; rd_m = '0;
        end else begin
            pend_v = (w >= 0);
            if (w >= 0) begin
                pend_m = w; ptr_m = w; rd_m = mem[a];
            end
        end
    endtask

    logic [N-1:0] wr;
    logic [N-1:0] exp_wr [4];
    logic [31:0]  held;

    initial begin
        reset = 1'b1; m_read = '0; m_address = '0;
        mem[0] = 32'hCAFE_0001; mem[1] = 32'h5176_80DF;
        @(posedge clock); #1;

        // Reset state, then master 2 reads address 1.
        step(1'b1, 4'b0000, 4'b0000, wr);
        step(1'b1, 4'b0101, 4'b0000, wr);
        check_eq("reset_waitreq", wr, 4'b0101);
        step(1'b0, 4'b0100, 4'b0100, wr);
        check_eq("m2_waitreq", wr[2], 1'b0);
        check_eq("m2_valid", m_readdatavalid, 4'b0100);
        check_eq("m2_data", m_readdata, 32'h5176_80DF);

        // All four masters requesting continuously from reset.
        step(1'b1, 4'b0000, 4'b0000, wr);
        exp_wr[0] = 4'b1110; exp_wr[1] = 4'b1101; exp_wr[2] = 4'b1011; exp_wr[3] = 4'b0111;
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 4'b1111, 4'b1010, wr);
            check_eq("rr_order", wr, exp_wr[c % 4]);
            check_eq("rr_valid", m_readdatavalid, 4'b0001 << (c % 4));
        end

        // ptr = 3, then only master 1 requests; ptr becomes 1.
        step(1'b1, 4'b0000, 4'b0000, wr);
        step(1'b0, 4'b1000, 4'b0000, wr);
        step(1'b0, 4'b0010, 4'b0000, wr);
        check_eq("wrap_m1", wr, 4'b0000);
        step(1'b0, 4'b0111, 4'b0000, wr);
        check_eq("after_wrap", wr, 4'b0011);

        // Master 3 stalled behind master 0, then withdraws.
        step(1'b1, 4'b0000, 4'b0000, wr);
        step(1'b0, 4'b1001, 4'b1000, wr);
        check_eq("m3_stall", wr, 4'b1000);
        step(1'b0, 4'b0000, 4'b0000, wr);
        check_eq("m3_no_valid", m_readdatavalid, 4'b0000);
        step(1'b0, 4'b0000, 4'b0000, wr);

        // Reset right after master 1 is accepted kills its response.
        step(1'b0, 4'b0010, 4'b0010, wr);
        step(1'b1, 4'b0000, 4'b0000, wr);
        check_eq("rst_kill", m_readdatavalid, 4'b0000);
        step(1'b0, 4'b1011, 4'b0000, wr);
        check_eq("m0_first", wr, 4'b1010);

        // Idle for 5 cycles: data holds, ptr unchanged (last winner 0).
        step(1'b0, 4'b0000, 4'b0000, wr);
        held = mem[0];
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 4'b0000, 4'b0000, wr);
            check_eq("idle_hold", m_readdata, held);
        end
        step(1'b0, 4'b1111, 4'b0000, wr);
        check_eq("idle_ptr", wr, 4'b1101);

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            mem[0] = $urandom;
            mem[1] = $urandom;
            step(($urandom_range(0, 39) == 0), 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), wr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
